soc_system_hex_bank: RTL and testbench
======================================

Name: soc_system_hex_bank

Overview:
Parametrised multi-channel Avalon-MM output PIO that drives a bank of NUM_CH seven-segment (or general) output ports from one slave. Adds per-channel blink masking, a programmable blink-period prescaler, a global blank control and full register readback. It sits on the lightweight HPS-to-FPGA bridge in place of one single-register hex PIO per display.

Parameters:
NUM_CH, 6, number of output channels (1..8)
DATA_WIDTH, 8, bits per channel (1..32)
PRESCALE_WIDTH, 24, width of the blink period register and down-counter (1..32)
BLANK_ONES, 1, blanked channel value: 1 = all ones (segments off, active-low), 0 = all zeros

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  4  Avalon-MM word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero wait-state
out_port  out  NUM_CH*DATA_WIDTH  packed channel outputs; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous and active-low.
- A write occurs on a rising clk when chipselect=1 and write_n=0.
- Register map (word addresses):
  - 0..7: DATA[i], DATA_WIDTH bits, R/W; addresses >= NUM_CH are unmapped.
  - 8: BLINK_MASK, NUM_CH bits, R/W; bit i enables blinking on channel i.
  - 9: PERIOD, PRESCALE_WIDTH bits, R/W; blink half-period in clk cycles minus 1.
  - 10: CTRL, R/W bit0 = BLANK_ALL; RO bit1 = phase. A write with writedata[31]=1 restarts the blink timer.
  - 11..15: unmapped.
- Register writes: writedata[W-1:0] is used, upper bits are ignored. Writes to unmapped addresses or read-only bits have no effect.
- Reads:
  - readdata is combinational from the current address and registers, valid in the same cycle.
  - Unused upper bits read 0; unmapped addresses read 0.
  - chipselect does not gate readdata.
- Reset values:
  - All DATA = 0, BLINK_MASK = 0, PERIOD = 0, BLANK_ALL = 0.
  - counter = 0, phase = 1 (visible).
  - Therefore out_port = 0 and readdata = 0 at address 0.
- Blink timer:
  - PERIOD = 0: timer is idle; counter is held at 0 and phase is forced to 1.
  - PERIOD != 0: each cycle, if counter = 0 then phase toggles and counter loads PERIOD; otherwise counter decrements.
  - Phase therefore toggles every PERIOD+1 cycles.
  - Writing PERIOD does not disturb the running count; the new value applies at the next reload.
  - Restart write (CTRL with writedata[31]=1): on that edge counter loads PERIOD and phase is set to 1. Restart wins over a terminal count on the same edge.
  - Changing PERIOD from nonzero to 0 forces phase to 1 on the next edge.
- Output composition (combinational from registers; a data write is visible on out_port the cycle after the write edge):
  - BLANK_ALL = 1: channel i outputs the blank value.
  - Otherwise, BLINK_MASK[i] = 1 and phase = 0: channel i outputs the blank value.
  - Otherwise: channel i outputs DATA[i].
  - Blank value is all ones if BLANK_ONES=1, else all zeros.
- Simultaneous events:
  - Only one register can be written per cycle.
  - A mask write that lands on a phase-toggle edge takes effect together with the new phase.
- Reset mid-operation: all registers return to their reset values immediately, independent of clk, and the timer halts.

Test Plan:
1. Reset, then write DATA[0]=0x3F, DATA[5]=0x06 -> out_port[7:0]=0x3F and out_port[47:40]=0x06 one cycle after each write edge; readback at addresses 0 and 5 returns 0x0000003F and 0x00000006.
2. Write address 6 (NUM_CH=6) = 0xFF; read addresses 6, 12 and 15 -> all read 0, out_port unchanged. Write DATA[1]=0xFFFF_FF12 -> reads back 0x12.
3. PERIOD=3, BLINK_MASK=0x01, DATA[0]=0x40 -> out_port[7:0] alternates 0x40/0xFF every 4 cycles; channel 1 stays steady; CTRL bit1 tracks phase.
4. With the blink timer running, write CTRL=0x8000_0000 on the same edge the counter reaches 0 -> phase=1 and counter=PERIOD, no toggle. Then write PERIOD=0 -> phase=1 on the next edge and stays 1.
5. CTRL=0x1 (BLANK_ALL) -> every channel = 0xFF regardless of mask or phase; CTRL=0x0 restores the DATA values.
6. Deassert reset_n asynchronously mid-blink, between clk edges -> out_port=0, all reads return 0 (CTRL bit1 reads 1), and the timer holds after release until PERIOD is written again.

Source files
------------

// File: rtl/soc_system_hex_bank.sv
// Multi-channel Avalon-MM output PIO: per-channel data registers, blink masking
// driven by a programmable half-period prescaler, global blanking and full readback.
module soc_system_hex_bank #(
   parameter int NUM_CH         = 6,
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 24,
   parameter int BLANK_ONES     = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [3:0]                   address,
   input  logic                         chipselect,
   input  logic                         write_n,
   input  logic [31:0]                  writedata,
   output logic [31:0]                  readdata,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_port
);

   localparam logic [3:0]            NUM_CH_ADDR = 4'(NUM_CH);
   localparam logic [3:0]            ADDR_MASK   = 4'd8;
   localparam logic [3:0]            ADDR_PERIOD = 4'd9;
   localparam logic [3:0]            ADDR_CTRL   = 4'd10;
   localparam logic [DATA_WIDTH-1:0] BLANK_VAL   = (BLANK_ONES != 0) ? {DATA_WIDTH{1'b1}} : '0;

   // Eight slots keep the 3-bit address index exact; slots >= NUM_CH are never written.
   logic [DATA_WIDTH-1:0]     data_q [8];
   logic [NUM_CH-1:0]         blink_mask;
   logic [PRESCALE_WIDTH-1:0] period;
   logic [PRESCALE_WIDTH-1:0] counter;
   logic                      blank_all;
   logic                      phase;

   logic wr_en;
   logic restart;
   logic unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign restart      = wr_en && (address == ADDR_CTRL) && writedata[31];
   assign unused_wdata = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) data_q[i] <= '0;
         blink_mask <= '0;
         period     <= '0;
         blank_all  <= 1'b0;
      end else if (wr_en) begin
         if (address < NUM_CH_ADDR) begin
            data_q[address[2:0]] <= writedata[DATA_WIDTH-1:0];
         end else if (address == ADDR_MASK) begin
            blink_mask <= writedata[NUM_CH-1:0];
         end else if (address == ADDR_PERIOD) begin
            period <= writedata[PRESCALE_WIDTH-1:0];
         end else if (address == ADDR_CTRL) begin
            blank_all <= writedata[0];
         end
      end
   end

   // Restart takes priority over a terminal count landing on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter <= '0;
         phase   <= 1'b1;
      end else if (restart) begin
         counter <= period;
         phase   <= 1'b1;
      end else if (period == '0) begin
         counter <= '0;
         phase   <= 1'b1;
      end else if (counter == '0) begin
         counter <= period;
         phase   <= ~phase;
      end else begin
         counter <= counter - 1'b1;
      end
   end

   always_comb begin
      readdata = '0;
      if (address < NUM_CH_ADDR) begin
         readdata[DATA_WIDTH-1:0] = data_q[address[2:0]];
      end else if (address == ADDR_MASK) begin
         readdata[NUM_CH-1:0] = blink_mask;
      end else if (address == ADDR_PERIOD) begin
         readdata[PRESCALE_WIDTH-1:0] = period;
      end else if (address == ADDR_CTRL) begin
         readdata[1:0] = {phase, blank_all};
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign out_port[i*DATA_WIDTH +: DATA_WIDTH] =
         (blank_all || (blink_mask[i] && !phase)) ? BLANK_VAL : data_q[i];
   end

endmodule

// File: tb/tb_soc_system_hex_bank.sv
// Bench for soc_system_hex_bank: event-time model of the blink timer plus
// directed register traffic with hand-computed checkpoints.
module tb_soc_system_hex_bank;

   localparam int NCH = 6;
   localparam int DW  = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic [3:0]        address = '0;
   logic              chipselect = 1'b0;
   logic              write_n = 1'b1;
   logic [31:0]       writedata = '0;
   logic [31:0]       readdata;
   logic [NCH*DW-1:0] out_port;

   int n_cmp = 0;
   int n_err = 0;

   soc_system_hex_bank #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .PRESCALE_WIDTH(24), .BLANK_ONES(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
   );

   always #5 clk = ~clk;

   // Model: registers as plain values, blink phase as "absolute cycle of next toggle".
   logic [DW-1:0] m_data [NCH];
   logic [NCH-1:0] m_mask;
   longint         m_period;
   logic           m_blank;
   logic           m_phase;
   longint         m_next;
   longint         cyc;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) m_data[i] = '0;
         m_mask = '0; m_period = 0; m_blank = 1'b0; m_phase = 1'b1; m_next = 0; cyc = 0;
      end else begin
         if (chipselect && !write_n && address == 4'd10 && writedata[31]) begin
            m_phase = 1'b1; m_next = cyc + m_period + 1;
         end else if (m_period == 0) begin
            m_phase = 1'b1; m_next = cyc + 1;
         end else if (cyc == m_next) begin
            m_phase = ~m_phase; m_next = cyc + m_period + 1;
         end
         if (chipselect && !write_n) begin
            if (address < NCH) m_data[address] = writedata[DW-1:0];
            else if (address == 4'd8) m_mask = writedata[NCH-1:0];
            else if (address == 4'd9) m_period = longint'(writedata[23:0]);
            else if (address == 4'd10) m_blank = writedata[0];
         end
         cyc = cyc + 1;
      end
   end

   function automatic logic [NCH*DW-1:0] model_out();
      logic [NCH*DW-1:0] o;
      for (int i = 0; i < NCH; i++)
         o[i*DW +: DW] = (m_blank || (m_mask[i] && !m_phase)) ? {DW{1'b1}} : m_data[i];
      return o;
   endfunction

   function automatic logic [31:0] model_rd(input logic [3:0] a);
      if (a < NCH) return {24'd0, m_data[a]};
      if (a == 4'd8) return {26'd0, m_mask};
      if (a == 4'd9) return m_period[31:0];
      if (a == 4'd10) return {30'd0, m_phase, m_blank};
      return 32'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("model_out_port", 64'(out_port), 64'(model_out()));
      chk("model_readdata", 64'(readdata), 64'(model_rd(address)));
   end

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
      address = a; #1;
      chk(name, 64'(readdata), 64'(exp));
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: reset state and basic data writes
      chk("reset_out", 64'(out_port), 64'd0);
      rd_chk("reset_rd0", 4'd0, 32'd0);
      rd_chk("reset_ctrl", 4'd10, 32'd2);
      wr(4'd0, 32'h3F);
      chk("ch0_3f", 64'(out_port[7:0]), 64'h3F);
      wr(4'd5, 32'h06);
      chk("ch5_06", 64'(out_port[47:40]), 64'h06);
      rd_chk("rd0", 4'd0, 32'h3F);
      rd_chk("rd5", 4'd5, 32'h06);

      // 2: unmapped addresses and truncated write data
      wr(4'd6, 32'hFF);
      rd_chk("rd6", 4'd6, 32'd0);
      rd_chk("rd12", 4'd12, 32'd0);
      rd_chk("rd15", 4'd15, 32'd0);
      chk("out_after_unmapped", 64'(out_port), 64'h06_00_00_00_00_3F);
      wr(4'd1, 32'hFFFF_FF12);
      rd_chk("rd1_trunc", 4'd1, 32'h12);

      // 3: blinking channel 0 with PERIOD=3
      wr(4'd0, 32'h40);
      wr(4'd8, 32'h01);
      wr(4'd9, 32'd3);
      idle(1);
      chk("blink_off_1", 64'(out_port[7:0]), 64'hFF);
      chk("ch1_steady", 64'(out_port[15:8]), 64'h12);
      rd_chk("ctrl_phase0", 4'd10, 32'd0);
      idle(3);
      chk("blink_off_4", 64'(out_port[7:0]), 64'hFF);
      idle(1);
      chk("blink_on", 64'(out_port[7:0]), 64'h40);
      rd_chk("ctrl_phase1", 4'd10, 32'd2);

      // 4: restart on the terminal-count edge, then stop the timer
      idle(3);
      wr(4'd10, 32'h8000_0000);
      chk("restart_no_toggle", 64'(out_port[7:0]), 64'h40);
      rd_chk("restart_ctrl", 4'd10, 32'd2);
      idle(3);
      chk("restart_reloaded", 64'(out_port[7:0]), 64'h40);
      idle(1);
      chk("restart_toggle", 64'(out_port[7:0]), 64'hFF);
      wr(4'd9, 32'd0);
      chk("period0_write_edge", 64'(out_port[7:0]), 64'hFF);
      idle(1);
      chk("period0_forced", 64'(out_port[7:0]), 64'h40);
      idle(5);
      chk("period0_held", 64'(out_port[7:0]), 64'h40);

      // 5: global blank overrides everything
      wr(4'd8, 32'h3F);
      wr(4'd9, 32'd2);
      wr(4'd10, 32'h1);
      chk("blank_all", 64'(out_port), 64'hFFFF_FFFF_FFFF);
      idle(3);
      chk("blank_all_held", 64'(out_port), 64'hFFFF_FFFF_FFFF);
      wr(4'd9, 32'd0);
      wr(4'd10, 32'h0);
      chk("unblank", 64'(out_port), 64'h06_00_00_00_12_40);

      // 6: asynchronous reset mid-blink
      wr(4'd8, 32'h01);
      wr(4'd9, 32'd3);
      idle(2);
      #2 reset_n = 1'b0;
      #1 chk("async_reset_out", 64'(out_port), 64'd0);
      for (int a = 0; a < 16; a++)
         rd_chk("reset_rd", 4'(a), (a == 10) ? 32'd2 : 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      idle(10);
      chk("post_reset_out", 64'(out_port), 64'd0);
      rd_chk("post_reset_ctrl", 4'd10, 32'd2);
      wr(4'd0, 32'h5B);
      chk("post_reset_data", 64'(out_port[7:0]), 64'h5B);
      wr(4'd8, 32'h01);
      wr(4'd9, 32'd1);
      idle(1);
      chk("p1_off", 64'(out_port[7:0]), 64'hFF);
      idle(1);
      chk("p1_off_hold", 64'(out_port[7:0]), 64'hFF);
      idle(1);
      chk("p1_on", 64'(out_port[7:0]), 64'h5B);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
